// File: rtl/button_step_ctrl_pkg.sv
// Shared types and default timing for the button step controller.
//   step_state_t     : step-mode FSM states
//   DEF_*            : default timing constants for a 50 MHz clock
//   max3             : helper used to size the shared internal counter
package button_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } step_state_t;

  localparam int unsigned DEF_HOLD_TIME   = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_TIME = 5_000_000;   // 100 ms
  localparam int unsigned DEF_RUN_DIV     = 50_000;      // 1 kHz
  localparam int unsigned DEF_CNT_W       = 16;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_step_ctrl_if.sv
// Button/strobe bundle between the debouncers, the controller and the core.
//   step_btn_n, mode_btn_n : debounced active-low buttons
//   halt                   : core halted, suppresses strobes
//   cpu_en                 : one-cycle core enable strobe
//   run_mode               : 0 = step, 1 = run
//   step_count             : issued strobe count (wraps)
// master drives buttons/halt; slave is the controller.
interface button_step_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             step_btn_n;
  logic             mode_btn_n;
  logic             halt;
  logic             cpu_en;
  logic             run_mode;
  logic [CNT_W-1:0] step_count;

  modport master (
    output step_btn_n, mode_btn_n, halt,
    input  cpu_en, run_mode, step_count
  );

  modport slave (
    input  step_btn_n, mode_btn_n, halt,
    output cpu_en, run_mode, step_count
  );
endinterface

// File: rtl/button_step_ctrl_edge.sv
// Falling-edge (press) detector for an active-low button level.
//   clk, rst : clock, synchronous active-high reset
//   i_btn_n  : debounced button level, active low
//   o_press  : high for the cycle where the button is sampled low after high
// History resets to 1 (released) so a button held through reset yields a press.
module fall_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press
);
  logic r_hist;

  always_ff @(posedge clk) begin
    if (rst) r_hist <= 1'b1;
    else     r_hist <= i_btn_n;
  end

  assign o_press = r_hist & ~i_btn_n;
endmodule

// File: rtl/button_step_ctrl.sv
// Step/run enable controller for the RV32I core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : button_step_ctrl_if slave (buttons, halt in; cpu_en, run_mode,
//              step_count out)
// Step mode: strobe on press, again after HOLD_TIME held, then every
// REPEAT_TIME. Run mode: strobe every RUN_DIV cycles. halt masks strobes.
module button_step_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_TIME   = DEF_HOLD_TIME,
  parameter int unsigned REPEAT_TIME = DEF_REPEAT_TIME,
  parameter int unsigned RUN_DIV     = DEF_RUN_DIV,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  button_step_ctrl_if.slave bus
);
  localparam int unsigned MAXT = max3(HOLD_TIME, REPEAT_TIME, RUN_DIV);
  localparam int unsigned CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_TIME - 1);
  localparam logic [CW-1:0]    REPEAT_LAST = CW'(REPEAT_TIME - 1);
  localparam logic [CW-1:0]    DIV_LAST    = CW'(RUN_DIV - 1);
  localparam logic [CW-1:0]    CW_ONE      = CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic w_step_press;
  logic w_mode_press;

  step_state_t      r_state;
  logic [CW-1:0]    r_cnt;   // hold/repeat counter
  logic [CW-1:0]    r_div;   // run-mode divider
  logic             r_cpu_en;
  logic             r_run_mode;
  logic [CNT_W-1:0] r_step_count;

  fall_edge_detect u_step_edge (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (bus.step_btn_n),
    .o_press (w_step_press)
  );

  fall_edge_detect u_mode_edge (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (bus.mode_btn_n),
    .o_press (w_mode_press)
  );

  // Each strobe site masks with halt and bumps step_count in the same
  // cycle, so cpu_en and step_count always move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_div        <= '0;
      r_cpu_en     <= 1'b0;
      r_run_mode   <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_cpu_en <= 1'b0;
      if (w_mode_press) begin
        r_run_mode <= ~r_run_mode;
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_div      <= '0;
      end else if (r_run_mode) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        if (r_div == DIV_LAST) begin
          r_div    <= '0;
          r_cpu_en <= ~bus.halt;
          if (!bus.halt) r_step_count <= r_step_count + CNT_ONE;
        end else begin
          r_div <= r_div + CW_ONE;
        end
      end else begin
        r_div <= '0;
        case (r_state)
          S_IDLE: begin
            if (w_step_press) begin
              r_cnt    <= '0;
              r_state  <= S_HOLD;
              r_cpu_en <= ~bus.halt;
              if (!bus.halt) r_step_count <= r_step_count + CNT_ONE;
            end
          end
          S_HOLD, S_REPEAT: begin
            if (bus.step_btn_n) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else if (r_cnt == ((r_state == S_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
              r_cnt    <= '0;
              r_state  <= S_REPEAT;
              r_cpu_en <= ~bus.halt;
              if (!bus.halt) r_step_count <= r_step_count + CNT_ONE;
            end else begin
              r_cnt <= r_cnt + CW_ONE;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cpu_en     = r_cpu_en;
  assign bus.run_mode   = r_run_mode;
  assign bus.step_count = r_step_count;
endmodule
